neosd_wb_arb: RTL and testbench
===============================

Name: neosd_wb_arb

Overview:
- Two-master Wishbone (classic, non-pipelined) arbiter that shares the single neosd register port between a CPU master (m0) and a DMA/boot-loader master (m1).
- Grants are round-robin and held for the whole bus cycle (m_cyc).
- A bus watchdog terminates transfers that neosd never acknowledges with a one-cycle error, because neosd has no err output.
- Sits directly in front of the neosd wb_* port.

Parameters:
- TIMEOUT, 255, stalled cycles before a watchdog error (1..65535); 0 disables the watchdog.
- ADR_W, 32, address width of all address ports.

Ports:
- clk_i  in  1  system clock, rising edge
- rstn_i  in  1  synchronous, active-low reset
- m0_adr_i, m1_adr_i  in  ADR_W  master address
- m0_dat_i, m1_dat_i  in  32  master write data
- m0_we_i, m1_we_i  in  1  master write enable
- m0_sel_i, m1_sel_i  in  4  master byte selects
- m0_stb_i, m1_stb_i  in  1  master strobe
- m0_cyc_i, m1_cyc_i  in  1  master cycle
- m0_ack_o, m1_ack_o  out  1  ack to master
- m0_err_o, m1_err_o  out  1  watchdog error to master
- m0_dat_o, m1_dat_o  out  32  read data to master
- s_adr_o  out  ADR_W  to neosd wb_adr_i
- s_dat_o  out  32  to neosd wb_dat_i
- s_we_o  out  1  to neosd wb_we_i
- s_sel_o  out  4  to neosd wb_sel_i
- s_stb_o  out  1  to neosd wb_stb_i
- s_cyc_o  out  1  to neosd wb_cyc_i
- s_ack_i  in  1  from neosd wb_ack_o
- s_dat_i  in  32  from neosd wb_dat_o
- grant_o  out  2  one-hot current grant (00 when idle)
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rstn_i low at a clock edge): state=IDLE, grant=00, rr pointer=0 (m0 preferred), watchdog count=0.
  - All outputs are 0 during and after reset, including s_cyc_o, s_stb_o, ack, err, dat_o and timeout_o.
  - Reset mid-transfer abandons the transfer; no ack or err is issued.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Slave outputs are all 0; master ack/err/dat_o are 0.
  - If exactly one m_cyc is high, that master is granted at the next edge and the FSM enters BUSY.
  - If both are high, the master indicated by the rr pointer is granted; the pointer is 0 selects m0 and 1 selects m1.
  - Arbitration latency is 1 cycle: the slave sees the master's signals from the first BUSY cycle.
- BUSY with granted master g:
  - s_adr_o, s_dat_o, s_we_o and s_sel_o equal the m_g signals combinationally.
  - s_cyc_o = m_g cyc.
  - s_stb_o = m_g stb AND NOT err_cycle.
  - mg_ack_o = s_ack_i.
  - mg_dat_o = s_dat_i when s_ack_i is high, else 0.
  - mg_err_o = err_cycle.
  - The non-granted master sees ack=err=0 and dat_o=0; its requests are held off and it never sees a spurious ack.
- Release:
  - When m_g cyc is low at an edge, the FSM goes to IDLE, grant=00 and the rr pointer is set to the other master.
  - IDLE lasts at least one cycle between grants.
  - A master holding cyc across several strobes keeps the grant (block/locked sequences).
- Watchdog:
  - The counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i, on m_g stb low, and on leaving BUSY.
  - When count = TIMEOUT-1 and s_ack_i=0, the next cycle is err_cycle: mg_err_o=1, timeout_o=1 and s_stb_o=0, and the count clears.
  - If s_ack_i arrives in the same cycle the count reaches TIMEOUT-1, the ack wins and no error is issued.
  - ack and err are never high together.
  - With TIMEOUT=0 the counter is held at 0 and err never fires.
- Counter width is clog2(TIMEOUT+1); it never wraps.
- A stb issued without cyc is ignored.

Test Plan:
- Single m0 read: m0 cyc/stb with adr=0x4, neosd acks after 2 cycles with dat=0xCAFE0001 -> s_stb_o is high from cycle 1, m0_ack_o pulses once with m0_dat_o=0xCAFE0001, m1 outputs stay 0, grant_o=01 then 00.
- Simultaneous request after reset: m0 and m1 raise cyc on the same edge, each doing one write -> m0 is served first; after m0 drops cyc there is 1 IDLE cycle, then grant_o=10 and m1's write reaches s_dat_o unchanged.
- Fairness: both masters hold requests continuously for 6 transfers -> the grant sequence is m0, m1, m0, m1, m0, m1, with no master granted twice in a row.
- Locked burst: m1 holds cyc over 3 strobes while m0 requests -> all 3 m1 acks complete before m0 is granted.
- Watchdog, TIMEOUT=8: neosd never acks -> after 8 stalled cycles m_g err_o and timeout_o pulse for 1 cycle with s_stb_o low; ack never asserts. Repeat with the ack arriving on the 8th cycle -> ack only, no err.
- Reset mid-transfer: rstn_i pulled low during a BUSY stall -> the next cycle shows all outputs 0 and the FSM in IDLE; the next simultaneous request grants m0.

Source files
------------

// File: rtl/neosd_wb_arb.sv
// ============================================================================
// Module   : neosd_wb_arb
// Purpose  : Two-master Wishbone classic arbiter in front of the neosd
//            register port. Round-robin grant held for the whole bus cycle,
//            plus a bus watchdog that ends never-acknowledged transfers with a
//            one-cycle error, because neosd has no err output.
// Ports    : clk_i, rstn_i           - clock, synchronous active-low reset
//            m0_*/m1_* (inputs)      - master adr/dat/we/sel/stb/cyc
//            m0_*/m1_* (outputs)     - ack/err/read data back to each master
//            s_*_o / s_ack_i/s_dat_i - neosd wb_* slave port
//            grant_o                 - one-hot current grant (00 when idle)
//            timeout_o               - one-cycle pulse when the watchdog fires
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neosd_wb_arb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADR_W   = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  // master 0 (CPU)
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic             m0_stb_i,
  input  logic             m0_cyc_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [31:0]      m0_dat_o,
  // master 1 (DMA / boot loader)
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic             m1_stb_i,
  input  logic             m1_cyc_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [31:0]      m1_dat_o,
  // neosd slave port
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic             s_stb_o,
  output logic             s_cyc_o,
  input  logic             s_ack_i,
  input  logic [31:0]      s_dat_i,
  // status
  output logic [1:0]       grant_o,
  output logic             timeout_o
);

  // Counter wide enough to hold TIMEOUT-1 without wrapping.
  localparam int unsigned      CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit               WD_EN   = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       grant;
  logic             rr_ptr;     // 0: m0 wins a tie, 1: m1 wins a tie
  logic [CNT_W-1:0] wd_cnt;
  logic             err_cycle;  // watchdog error beat in progress

  // Grant qualified by reset so every output reads 0 while rstn_i is low,
  // not only after the reset edge has been registered.
  logic act0;
  logic act1;
  logic g_cyc;
  logic g_stb;
  logic ack_ok;

  assign act0   = grant[0] & rstn_i;
  assign act1   = grant[1] & rstn_i;
  assign g_cyc  = (act0 & m0_cyc_i) | (act1 & m1_cyc_i);
  assign g_stb  = (act0 & m0_stb_i) | (act1 & m1_stb_i);
  // The error beat owns the cycle: a late ack is never forwarded with err.
  assign ack_ok = s_ack_i & ~err_cycle;

  // Slave side follows the granted master combinationally.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    if (act0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
    end else if (act1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
    end
  end

  assign s_cyc_o   = g_cyc;
  // A strobe without cycle is ignored; the strobe is withdrawn on the error beat.
  assign s_stb_o   = g_cyc & g_stb & ~err_cycle;

  assign m0_ack_o  = act0 & ack_ok;
  assign m1_ack_o  = act1 & ack_ok;
  assign m0_err_o  = act0 & err_cycle;
  assign m1_err_o  = act1 & err_cycle;
  assign m0_dat_o  = (act0 & ack_ok) ? s_dat_i : 32'h0;
  assign m1_dat_o  = (act1 & ack_ok) ? s_dat_i : 32'h0;

  assign grant_o   = grant & {2{rstn_i}};
  assign timeout_o = err_cycle & rstn_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      grant     <= 2'b00;
      rr_ptr    <= 1'b0;
      wd_cnt    <= '0;
      err_cycle <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt    <= '0;
          err_cycle <= 1'b0;
          if (m0_cyc_i && (!m1_cyc_i || !rr_ptr)) begin
            grant <= 2'b01;
            state <= ST_BUSY;
          end else if (m1_cyc_i) begin
            grant <= 2'b10;
            state <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (!g_cyc) begin
            // Cycle ended: release and hand priority to the other master.
            state     <= ST_IDLE;
            grant     <= 2'b00;
            rr_ptr    <= grant[0];
            wd_cnt    <= '0;
            err_cycle <= 1'b0;
          end else if (err_cycle) begin
            err_cycle <= 1'b0;
            wd_cnt    <= '0;
          end else if (!WD_EN || s_ack_i || !s_stb_o) begin
            wd_cnt <= '0;
          end else if (wd_cnt == CNT_MAX) begin
            err_cycle <= 1'b1;
            wd_cnt    <= '0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neosd_wb_arb.sv
// ============================================================================
// Module   : tb_neosd_wb_arb
// Purpose  : Self-checking bench for neosd_wb_arb (TIMEOUT=8). Master tasks
//            push expected responses into per-master queues; a monitor pops
//            and compares whenever a master sees ack or err, and checks the
//            grant order against a hand-written grant queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neosd_wb_arb;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned ADR_W   = 32;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [ADR_W-1:0] m0_adr_i, m1_adr_i;
  logic [31:0]      m0_dat_i, m1_dat_i;
  logic             m0_we_i, m1_we_i;
  logic [3:0]       m0_sel_i, m1_sel_i;
  logic             m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
  logic             m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0]      m0_dat_o, m1_dat_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [31:0]      s_dat_o;
  logic             s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]       s_sel_o;
  logic             s_ack_i;
  logic [31:0]      s_dat_i;
  logic [1:0]       grant_o;
  logic             timeout_o;

  neosd_wb_arb #(.TIMEOUT(TIMEOUT), .ADR_W(ADR_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic [31:0] rdat;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
  } sb_t;

  sb_t        exp0[$];
  sb_t        exp1[$];
  logic [1:0] gq[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         ack_delay = 1;  // neosd model: 0 = never acknowledge

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_stb_o,
                         s_cyc_o, grant_o, timeout_o, s_sel_o}, 64'h0);
    chk({name, "_mdat"}, {m0_dat_o, m1_dat_o}, 64'h0);
    chk({name, "_sbus"}, {s_adr_o, s_dat_o}, 64'h0);
  endtask

  // neosd model: acks ack_delay cycles into a strobe; read data = CAFE_00xx with
  // xx = word index adr[5:2].
  initial begin
    int w;
    w = 0;
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #2;
      if (s_stb_o && !s_ack_i) begin
        w++;
        if (ack_delay != 0 && w == ack_delay) begin
          s_ack_i = 1'b1;
          s_dat_i = {16'hCAFE, 12'h000, s_adr_o[5:2]};
        end
      end else begin
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
        w = 0;
      end
    end
  end

  task automatic check_evt(input int m);
    sb_t         e;
    logic        ack, err, oack, oerr;
    logic [31:0] dat, odat;
    ack  = (m == 0) ? m0_ack_o : m1_ack_o;
    err  = (m == 0) ? m0_err_o : m1_err_o;
    dat  = (m == 0) ? m0_dat_o : m1_dat_o;
    oack = (m == 0) ? m1_ack_o : m0_ack_o;
    oerr = (m == 0) ? m1_err_o : m0_err_o;
    odat = (m == 0) ? m1_dat_o : m0_dat_o;
    if ((m == 0 && exp0.size() == 0) || (m == 1 && exp1.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_evt m%0d: got ack=%0b err=%0b expected none", m, ack, err);
      return;
    end
    e = (m == 0) ? exp0.pop_front() : exp1.pop_front();
    chk("evt_ack_err", {ack, err}, e.err ? 2'b01 : 2'b10);
    chk("rd_dat", dat, e.err ? 32'h0 : e.rdat);
    chk("s_adr", s_adr_o, e.adr);
    chk("s_we", s_we_o, e.we);
    chk("s_sel", s_sel_o, e.sel);
    if (e.we && !e.err) chk("s_dat", s_dat_o, e.wdat);
    chk("timeout_o", timeout_o, e.err);
    chk("s_stb", s_stb_o, !e.err);
    chk("other_idle", {oack, oerr, odat}, 64'h0);
  endtask

  // Monitor: pops the scoreboard on every ack/err and tracks grant order.
  initial begin
    logic [1:0] prev_grant;
    prev_grant = 2'b00;
    forever begin
      @(negedge clk_i);
      if (m0_ack_o || m0_err_o) check_evt(0);
      if (m1_ack_o || m1_err_o) check_evt(1);
      if (grant_o != prev_grant && grant_o != 2'b00) begin
        chk("idle_gap", prev_grant, 2'b00);
        if (gq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_grant: got %b expected none", grant_o);
        end else begin
          chk("grant_seq", grant_o, gq.pop_front());
        end
      end
      prev_grant = grant_o;
    end
  end

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic [31:0] adr,
                       input logic [31:0] dat, input logic we);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_dat_i = dat; m0_we_i = we;
      m0_sel_i = 4'h3;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_dat_i = dat; m1_we_i = we;
      m1_sel_i = 4'hC;
    end
  endtask

  // One bus cycle of nstb strobes (addresses step by 4, write data by 1,
  // expected read data by 1). lat = negedges from raise to the last response.
  task automatic m_txn(input int m, input int nstb, input logic [31:0] adr, input logic we,
                       input logic [31:0] wdat, input logic [31:0] exp_rd,
                       input logic exp_err, output int lat);
    sb_t  e;
    logic got, was_err;
    lat = 0;
    @(posedge clk_i);
    #1;
    set_m(m, 1'b1, 1'b1, adr, wdat, we);
    for (int i = 0; i < nstb; i++) begin
      e.err = exp_err; e.rdat = exp_rd + i; e.adr = adr + 4 * i; e.wdat = wdat + i;
      e.we = we; e.sel = (m == 0) ? 4'h3 : 4'hC;
      if (m == 0) exp0.push_back(e); else exp1.push_back(e);
      got = 1'b0;
      was_err = 1'b0;
      lat = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk_i);
        lat++;
        if ((m == 0) ? (m0_ack_o || m0_err_o) : (m1_ack_o || m1_err_o)) begin
          got = 1'b1;
          was_err = (m == 0) ? m0_err_o : m1_err_o;
        end
      end
      if (!got) begin
        n_cmp++;
        n_fail++;
        $display("FAIL m%0d_wait: got no response expected ack/err within 200 cycles", m);
      end
      @(posedge clk_i);
      #1;
      if (i < nstb - 1 && got && !was_err)
        set_m(m, 1'b1, 1'b1, adr + 4 * (i + 1), wdat + i + 1, we);
      else begin
        set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    int lat0, lat1;
    rstn_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("reset_state");
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    // Single m0 read, neosd acks in the 2nd BUSY cycle.
    ack_delay = 2;
    gq.push_back(2'b01);
    m_txn(0, 1, 32'h4, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, lat0);
    chk("t1_latency", 64'(lat0), 64'd3);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("t1_grant_idle", grant_o, 2'b00);

    // Simultaneous writes after reset: m0 first, then m1.
    do_reset();
    ack_delay = 1;
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    fork
      m_txn(0, 1, 32'h8, 1'b1, 32'h11110000, 32'hCAFE0002, 1'b0, lat0);
      m_txn(1, 1, 32'hC, 1'b1, 32'h22220000, 32'hCAFE0003, 1'b0, lat1);
    join
    chk("t2_m0_latency", 64'(lat0), 64'd2);
    chk("t2_m1_latency", 64'(lat1), 64'd5);
    repeat (3) @(posedge clk_i);

    // Fairness: both request continuously, 6 transfers alternate.
    for (int i = 0; i < 3; i++) begin
      gq.push_back(2'b01);
      gq.push_back(2'b10);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) m_txn(0, 1, 32'h10, 1'b0, 32'h0, 32'hCAFE0004, 1'b0, lat0);
      end
      begin
        for (int j = 0; j < 3; j++) m_txn(1, 1, 32'h14, 1'b0, 32'h0, 32'hCAFE0005, 1'b0, lat1);
      end
    join
    repeat (3) @(posedge clk_i);

    // Locked burst: m1 keeps the bus for 3 strobes while m0 waits.
    ack_delay = 2;
    gq.push_back(2'b10);
    gq.push_back(2'b01);
    fork
      m_txn(1, 3, 32'h18, 1'b1, 32'h000000A0, 32'hCAFE0006, 1'b0, lat1);
      begin
        repeat (2) @(posedge clk_i);
        m_txn(0, 1, 32'h4, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, lat0);
      end
    join
    repeat (3) @(posedge clk_i);

    // Watchdog: never acked -> err after 8 stalled cycles.
    ack_delay = 0;
    gq.push_back(2'b01);
    m_txn(0, 1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1, lat0);
    chk("wd_err_latency", 64'(lat0), 64'd10);
    repeat (3) @(posedge clk_i);
    // Ack on the 8th stalled cycle wins over the watchdog.
    ack_delay = 8;
    gq.push_back(2'b10);
    m_txn(1, 1, 32'h8, 1'b0, 32'h0, 32'hCAFE0002, 1'b0, lat1);
    chk("wd_ack_latency", 64'(lat1), 64'd9);
    repeat (3) @(posedge clk_i);

    // Reset in the middle of a stalled m1 transfer.
    ack_delay = 0;
    gq.push_back(2'b10);
    @(posedge clk_i);
    #1;
    set_m(1, 1'b1, 1'b1, 32'h8, 32'h0, 1'b0);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("mid_busy_stb", {s_stb_o, grant_o}, 3'b110);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk_i);
    chk_all_zero("in_reset");
    @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("after_reset");
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    ack_delay = 1;
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    fork
      m_txn(0, 1, 32'h10, 1'b0, 32'h0, 32'hCAFE0004, 1'b0, lat0);
      m_txn(1, 1, 32'h14, 1'b0, 32'h0, 32'hCAFE0005, 1'b0, lat1);
    join
    repeat (3) @(posedge clk_i);

    chk("exp0_left", 64'(exp0.size()), 64'd0);
    chk("exp1_left", 64'(exp1.size()), 64'd0);
    chk("grants_left", 64'(gq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish before 200000");
    $fatal(1, "bench time limit reached");
  end

endmodule

`default_nettype wire
